// File: rtl/multi_port_mem_ctrl.sv
// Multi-port byte-serial memory controller: round-robin grant, one 1/2/4-byte transfer in flight.
// Optional MPMC_IO_STALL_EN: hold IO-window (addr[17:16]==2'b11) store bytes while io_buffer_full is high.
module multi_port_mem_ctrl #(
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned FLUSH_MASK = 1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush_in,
    input  logic                    io_buffer_full,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [31:0]             mem_a,
    output logic                    mem_wr,
    input  logic [NUM_PORTS-1:0]    req_valid_in,
    input  logic [NUM_PORTS-1:0]    req_wr_in,
    input  logic [32*NUM_PORTS-1:0] req_addr_in,
    input  logic [3*NUM_PORTS-1:0]  req_len_in,
    input  logic [32*NUM_PORTS-1:0] req_wdata_in,
    output logic [NUM_PORTS-1:0]    resp_valid_out,
    output logic [31:0]             resp_rdata_out
);
    localparam int unsigned PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [7:0]  FMASK = 8'(FLUSH_MASK);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        port_q, port_d, rr_q, rr_d;
    logic [31:0]          addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0]          buf_q, buf_d, rdata_q, rdata_d, mem_a_q, mem_a_d;
    logic [1:0]           lenm1_q, lenm1_d, idx_q, idx_d, rx_idx_q, rx_idx_d;
    logic                 act_q, act_d, rx_vld_q, rx_vld_d, last_q, last_d;
    logic                 mem_wr_q, mem_wr_d;
    logic [7:0]           mem_dout_q, mem_dout_d;
    logic [NUM_PORTS-1:0] resp_q, resp_d;
    logic [1:0]           idx_nx_c;
    logic                 io_stall_c, got_last_c, grant_found;
    int                   cand, gi;

`ifdef MPMC_IO_STALL_EN
    assign io_stall_c = (state_q == WRITE) && io_buffer_full && (mem_a_q[17:16] == 2'b11);
`else
    logic unused_io_full;
    assign unused_io_full = io_buffer_full;
    assign io_stall_c     = 1'b0;
`endif

    assign idx_nx_c   = idx_q + 2'd1;
    assign got_last_c = last_q || (rx_vld_q && (rx_idx_q == lenm1_q));

    // Next-state, grant arbitration and byte sequencing
    always_comb begin
        state_d    = state_q;
        port_d     = port_q;
        rr_d       = rr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lenm1_d    = lenm1_q;
        idx_d      = idx_q;
        act_d      = act_q;
        buf_d      = buf_q;
        last_d     = last_q;
        rdata_d    = rdata_q;
        resp_d     = resp_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        grant_found = 1'b0;
        cand       = 0;
        gi         = 0;

        // Read byte lands one cycle after its address; recapture while frozen is harmless
        rx_vld_d = (state_q == READ) && act_q;
        rx_idx_d = idx_q;
        if (rx_vld_q) begin
            buf_d[{rx_idx_q, 3'b000} +: 8] = mem_din;
        end
        if (state_q == READ) begin
            last_d = got_last_c;
        end

        if (rdy_in) begin
            resp_d  = '0;
            rdata_d = '0;
            case (state_q)
                IDLE: begin
                    mem_a_d    = '0;
                    mem_dout_d = '0;
                    mem_wr_d   = 1'b0;
                    for (int off = 1; off <= int'(NUM_PORTS); off++) begin
                        cand = (int'(rr_q) + off) % int'(NUM_PORTS);
                        if (!grant_found && req_valid_in[cand] && !(flush_in && FMASK[cand])) begin
                            grant_found = 1'b1;
                            gi          = cand;
                        end
                    end
                    if (grant_found) begin
                        port_d  = PW'(gi);
                        rr_d    = PW'(gi);
                        addr_d  = req_addr_in[32*gi +: 32];
                        wdata_d = req_wdata_in[32*gi +: 32];
                        mem_a_d = req_addr_in[32*gi +: 32];
                        idx_d   = 2'd0;
                        last_d  = 1'b0;
                        case (req_len_in[3*gi +: 3])
                            3'd1:    lenm1_d = 2'd0;
                            3'd2:    lenm1_d = 2'd1;
                            default: lenm1_d = 2'd3;
                        endcase
                        if (req_wr_in[gi]) begin
                            state_d    = WRITE;
                            mem_wr_d   = 1'b1;
                            mem_dout_d = req_wdata_in[32*gi +: 8];
                        end else begin
                            state_d = READ;
                            act_d   = 1'b1;
                            buf_d   = '0;
                        end
                    end
                end
                READ: begin
                    if (flush_in && FMASK[port_q]) begin
                        state_d = IDLE;
                        act_d   = 1'b0;
                        mem_a_d = '0;
                    end else if (act_q) begin
                        if (idx_q == lenm1_q) begin
                            act_d   = 1'b0;
                            mem_a_d = '0;
                        end else begin
                            idx_d   = idx_nx_c;
                            mem_a_d = addr_q + 32'(idx_nx_c);
                        end
                    end else if (got_last_c) begin
                        state_d         = IDLE;
                        resp_d[port_q]  = 1'b1;
                        rdata_d         = buf_d;
                    end
                end
                WRITE: begin
                    if (!io_stall_c) begin
                        if (idx_q == lenm1_q) begin
                            state_d        = IDLE;
                            resp_d[port_q] = 1'b1;
                            mem_a_d        = '0;
                            mem_dout_d     = '0;
                            mem_wr_d       = 1'b0;
                        end else begin
                            idx_d      = idx_nx_c;
                            mem_a_d    = addr_q + 32'(idx_nx_c);
                            mem_dout_d = wdata_q[{idx_nx_c, 3'b000} +: 8];
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            port_q     <= '0;
            rr_q       <= PW'(NUM_PORTS - 1);
            addr_q     <= '0;
            wdata_q    <= '0;
            lenm1_q    <= '0;
            idx_q      <= '0;
            act_q      <= 1'b0;
            rx_vld_q   <= 1'b0;
            rx_idx_q   <= '0;
            last_q     <= 1'b0;
            buf_q      <= '0;
            rdata_q    <= '0;
            resp_q     <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_q     <= port_d;
            rr_q       <= rr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lenm1_q    <= lenm1_d;
            idx_q      <= idx_d;
            act_q      <= act_d;
            rx_vld_q   <= rx_vld_d;
            rx_idx_q   <= rx_idx_d;
            last_q     <= last_d;
            buf_q      <= buf_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    // Strobes are masked at once by a freeze or IO stall, then re-issued on resume
    assign mem_a          = mem_a_q;
    assign mem_dout       = mem_dout_q;
    assign mem_wr         = mem_wr_q & rdy_in & ~io_stall_c;
    assign resp_valid_out = resp_q & {NUM_PORTS{rdy_in}};
    assign resp_rdata_out = rdata_q;

endmodule

// File: tb/tb_multi_port_mem_ctrl.sv
// Self-checking bench for multi_port_mem_ctrl: synchronous byte memory model plus response scoreboard.
module tb_multi_port_mem_ctrl;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in, io_buffer_full;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [1:0]  req_valid_in, req_wr_in;
    logic [63:0] req_addr_in, req_wdata_in;
    logic [5:0]  req_len_in;
    logic [1:0]  resp_valid_out;
    logic [31:0] resp_rdata_out;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] keep;
    logic [7:0] mem [0:4095];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         g;

    multi_port_mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .req_valid_in(req_valid_in), .req_wr_in(req_wr_in),
        .req_addr_in(req_addr_in), .req_len_in(req_len_in), .req_wdata_in(req_wdata_in),
        .resp_valid_out(resp_valid_out), .resp_rdata_out(resp_rdata_out)
    );

    initial forever #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Synchronous memory: one-cycle read latency, preloaded while reset is low
    always @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
            mem[12'h100] <= 8'h11;
            mem[12'h101] <= 8'h22;
            mem[12'h102] <= 8'h33;
            mem[12'h103] <= 8'h44;
            mem[12'hFFF] <= 8'h99;
            mem[12'h000] <= 8'h77;
        end else if (mem_wr) begin
            mem[mem_a[11:0]] <= mem_dout;
        end
        mem_din <= mem[mem_a[11:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and score any response seen there
    task automatic tick();
        exp_t e;
        @(negedge clk_in);
        if (resp_valid_out != 2'b00) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected", 32'(resp_valid_out), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("resp_port", 32'(resp_valid_out), 32'(1) << e.port);
                check("resp_rdata", resp_rdata_out, e.rdata);
                if (e.due >= 0) check("resp_cycle", 32'(cyc), 32'(e.due));
                if (!keep[e.port]) req_valid_in[e.port] = 1'b0;
            end
        end
    endtask

    task automatic set_req(input int p, input logic wr, input logic [31:0] addr,
                           input logic [2:0] len, input logic [31:0] wd);
        req_wr_in[p]              = wr;
        req_addr_in[32*p +: 32]   = addr;
        req_len_in[3*p +: 3]      = len;
        req_wdata_in[32*p +: 32]  = wd;
        req_valid_in[p]           = 1'b1;
    endtask

    task automatic push(input int p, input logic [31:0] rd, input int due);
        exp_q.push_back('{port: p, rdata: rd, due: due});
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        tick();
    endtask

    initial begin
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; io_buffer_full = 1'b0;
        req_valid_in = '0; req_wr_in = '0; req_addr_in = '0; req_len_in = '0;
        req_wdata_in = '0; keep = '0;
        repeat (3) tick();
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_wr", 32'(mem_wr), 32'h0);
        check("rst_mem_dout", 32'(mem_dout), 32'h0);
        check("rst_resp", 32'(resp_valid_out), 32'h0);
        check("rst_rdata", resp_rdata_out, 32'h0);
        rst_in = 1'b1;
        tick();

        // Port 0 read, 4 bytes
        g = cyc + 1;
        set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
        push(0, 32'h44332211, g + 5);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rd4_mem_a", mem_a, 32'h100 + 32'(k));
            check("rd4_mem_wr", 32'(mem_wr), 32'h0);
        end
        drain(20);

        // Port 1 write, 2 bytes; flush during a write is ignored
        g = cyc + 1;
        set_req(1, 1'b1, 32'h200, 3'd2, 32'hAABBCCDD);
        push(1, 32'h0, g + 2);
        tick();
        flush_in = 1'b1;
        check("wr2_b0", {mem_wr, mem_a[23:0], mem_dout[6:0]}, {1'b1, 24'h000200, 7'h5D});
        check("wr2_d0", 32'(mem_dout), 32'hDD);
        tick();
        flush_in = 1'b0;
        check("wr2_a1", mem_a, 32'h201);
        check("wr2_d1", 32'(mem_dout), 32'hCC);
        drain(20);
        check("wr2_mem", {mem[12'h201], mem[12'h200]}, 32'h0000CCDD);
        check("wr2_idle_wr", 32'(mem_wr), 32'h0);

        // Both ports requesting continuously alternate 0,1,0,1
        keep = 2'b11;
        set_req(0, 1'b1, 32'h210, 3'd1, 32'h01);
        set_req(1, 1'b1, 32'h211, 3'd1, 32'h02);
        for (int k = 0; k < 4; k++) push(k % 2, 32'h0, -1);
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick();
        req_valid_in = '0;
        keep = '0;
        drain(5);
        check("rr_mem", {mem[12'h211], mem[12'h210]}, 32'h00000201);

        // Flush aborts a masked-port read; pending port 1 follows
        g = cyc + 1;
        set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
        set_req(1, 1'b1, 32'h220, 3'd1, 32'h5A);
        push(1, 32'h0, g + 4);
        tick();
        tick();
        flush_in = 1'b1;
        req_valid_in[0] = 1'b0;
        tick();
        flush_in = 1'b0;
        check("flush_idle_a", mem_a, 32'h0);
        drain(20);
        check("flush_wr_mem", 32'(mem[12'h220]), 32'h5A);

        // Flush in IDLE blocks masked port 0; port 1 granted first
        g = cyc + 1;
        flush_in = 1'b1;
        set_req(0, 1'b0, 32'h102, 3'd2, 32'h0);
        set_req(1, 1'b0, 32'h100, 3'd1, 32'h0);
        push(1, 32'h11, g + 2);
        push(0, 32'h4433, g + 6);
        tick();
        flush_in = 1'b0;
        drain(20);

        // Flush has no effect on an unmasked-port read
        g = cyc + 1;
        set_req(1, 1'b0, 32'h101, 3'd2, 32'h0);
        push(1, 32'h3322, g + 3);
        tick();
        flush_in = 1'b1;
        tick();
        tick();
        flush_in = 1'b0;
        drain(20);

        // rdy_in low for 2 cycles mid-read
        g = cyc + 1;
        set_req(0, 1'b0, 32'h100, 3'd4, 32'h0);
        push(0, 32'h44332211, g + 7);
        tick();
        tick();
        rdy_in = 1'b0;
        tick();
        check("frz_a0", mem_a, 32'h101);
        check("frz_wr", 32'(mem_wr), 32'h0);
        tick();
        check("frz_a1", mem_a, 32'h101);
        rdy_in = 1'b1;
        drain(20);

        // rdy_in low on a write byte masks mem_wr and delays the store
        g = cyc + 1;
        set_req(1, 1'b1, 32'h230, 3'd2, 32'h1234);
        push(1, 32'h0, g + 3);
        tick();
        rdy_in = 1'b0;
        #1;
        check("frzw_wr0", 32'(mem_wr), 32'h0);
        tick();
        rdy_in = 1'b1;
        #1;
        check("frzw_wr1", {31'h0, mem_wr} | (mem_a << 1), {31'h0, 1'b1} | (32'h230 << 1));
        drain(20);
        check("frzw_mem", {mem[12'h231], mem[12'h230]}, 32'h00001234);

        // Illegal length 3 behaves as 4
        g = cyc + 1;
        set_req(0, 1'b0, 32'h100, 3'd3, 32'h0);
        push(0, 32'h44332211, g + 5);
        drain(20);

        // Address wraps past 0xFFFFFFFF
        g = cyc + 1;
        set_req(1, 1'b0, 32'hFFFF_FFFF, 3'd2, 32'h0);
        push(1, 32'h7799, g + 3);
        tick();
        check("wrap_a0", mem_a, 32'hFFFF_FFFF);
        tick();
        check("wrap_a1", mem_a, 32'h0);
        drain(20);

        // IO-window write with io_buffer_full high for 3 cycles
        g = cyc + 1;
        io_buffer_full = 1'b1;
        set_req(0, 1'b1, 32'h0003_0000, 3'd1, 32'hA5);
`ifdef MPMC_IO_STALL_EN
        push(0, 32'h0, g + 4);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("io_stall_wr", 32'(mem_wr), 32'h0);
            check("io_stall_a", mem_a, 32'h0003_0000);
        end
        tick();
        io_buffer_full = 1'b0;
        #1;
        check("io_release_wr", 32'(mem_wr), 32'h1);
`else
        push(0, 32'h0, g + 1);
        tick();
        check("io_ignored_wr", 32'(mem_wr), 32'h1);
        tick();
        io_buffer_full = 1'b0;
`endif
        drain(20);
        check("io_mem", 32'(mem[12'h000]), 32'hA5);

        // Asynchronous reset mid-write abandons it and restores port-0 priority
        set_req(0, 1'b1, 32'h300, 3'd4, 32'hDEADBEEF);
        tick();
        tick();
        check("pre_rst_wr", 32'(mem_wr), 32'h1);
        req_valid_in = '0;
        #2 rst_in = 1'b0;
        #1;
        check("arst_mem_wr", 32'(mem_wr), 32'h0);
        check("arst_mem_a", mem_a, 32'h0);
        check("arst_dout", 32'(mem_dout), 32'h0);
        tick();
        tick();
        rst_in = 1'b1;
        check("arst_no_resp", 32'(exp_q.size()), 32'h0);
        g = cyc + 1;
        set_req(0, 1'b0, 32'h100, 3'd1, 32'h0);
        set_req(1, 1'b0, 32'h101, 3'd1, 32'h0);
        push(0, 32'h11, g + 2);
        push(1, 32'h22, g + 5);
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/multi_port_mem_ctrl.md
MULTI_PORT_MEM_CTRL -- requirements
Module: multi_port_mem_ctrl

Interface
REQ-001 Clock and reset SHALL be one clock (clk_in) and an asynchronous, active-low reset (rst_in); all state SHALL clear immediately when rst_in falls, regardless of clk_in.
REQ-002 Parameter NUM_PORTS, default 2: number of requester ports; valid range 1..8.
REQ-003 Parameter FLUSH_MASK, default 1 (port 0 only): bit i set means port i reads are abortable by flush_in.
REQ-004 clk_in  input  1  system clock.
REQ-005 rst_in  input  1  asynchronous active-low reset.
REQ-006 rdy_in  input  1  global ready; low freezes the block.
REQ-007 flush_in  input  1  misprediction flush.
REQ-008 io_buffer_full  input  1  UART transmit buffer full.
REQ-009 mem_din  input  8  memory read byte.
REQ-010 mem_dout  output  8  memory write byte.
REQ-011 mem_a  output  32  memory byte address.
REQ-012 mem_wr  output  1  1 = write, 0 = read.
REQ-013 req_valid_in  input  NUM_PORTS  per-port request valid.
REQ-014 req_wr_in  input  NUM_PORTS  per-port 1 = store.
REQ-015 req_addr_in  input  32*NUM_PORTS  per-port start address; port i occupies bits [32i+31:32i].
REQ-016 req_len_in  input  3*NUM_PORTS  per-port byte count; only 1, 2 or 4 are legal.
REQ-017 req_wdata_in  input  32*NUM_PORTS  per-port store data, little-endian.
REQ-018 resp_valid_out  output  NUM_PORTS  one-cycle completion pulse per port.
REQ-019 resp_rdata_out  output  32  load data, zero-extended, valid while any resp_valid_out bit is high.

Function
REQ-020 States SHALL be IDLE, READ and WRITE; only one transaction SHALL be in flight at a time.
REQ-021 In IDLE, the block SHALL grant one asserted request by round-robin, searching from the port after the last granted port; latch port, addr, len, wdata and direction at grant edge G; then enter READ or WRITE.
REQ-022 A requester SHALL hold its request stable until its resp_valid_out pulse; the block SHALL ignore request changes outside IDLE.
REQ-023 Byte k (k=0..L-1) SHALL be addressed at mem_a = addr+k during cycle G+1+k; 32-bit address arithmetic wraps.
REQ-024 READ: the byte on mem_din in cycle G+2+k SHALL be placed in rdata bits [8k+7:8k]; resp_valid_out[port] SHALL be high in cycle G+L+2; unused upper bytes SHALL be 0.
REQ-025 WRITE: mem_wr=1 and mem_dout=wdata byte k in cycle G+1+k; resp_valid_out[port] SHALL be high in cycle G+L+1; resp_rdata_out SHALL be 0.
REQ-026 The block SHALL return to IDLE in the cycle it asserts resp; a new grant SHALL be possible in that same cycle (back-to-back).
REQ-027 Outside active byte cycles, mem_a, mem_dout and mem_wr SHALL be driven 0.
REQ-028 flush_in high during READ of a FLUSH_MASK port SHALL abort the read: IDLE on the next edge, no resp pulse.
REQ-029 flush_in high during WRITE, or during READ of an unmasked port, SHALL have no effect.
REQ-030 flush_in high in IDLE SHALL block grants to masked ports that cycle; unmasked ports SHALL still be granted.
REQ-031 rdy_in low SHALL freeze state, counters and round-robin pointer, force mem_wr=0, and suppress resp pulses; operation SHALL resume on the same byte when rdy_in returns high.
REQ-032 Illegal req_len values SHALL be treated as 4.

Reset
REQ-033 On rst_in low, state SHALL be IDLE; mem_a, mem_dout, mem_wr, resp_valid_out and resp_rdata_out SHALL be 0; the round-robin pointer SHALL be NUM_PORTS-1, so port 0 wins first.
REQ-034 Reset mid-transaction SHALL abandon that transaction with no resp pulse; any partial store SHALL be left in memory.

Configuration
REQ-035 With macro MPMC_IO_STALL_EN defined, a WRITE byte whose address has bits [17:16]==2'b11 SHALL be held while io_buffer_full=1: mem_wr=0, byte index frozen, resp delayed one cycle per stalled cycle.
REQ-036 Without MPMC_IO_STALL_EN, io_buffer_full SHALL be ignored.

Verification
REQ-037 Port0 read len4 @0x100, memory holds 0x11,0x22,0x33,0x44 -> mem_a 0x100..0x103 in G+1..G+4; resp_valid_out[0] high in G+6; rdata 0x44332211.
REQ-038 Port1 write len2 @0x200, wdata 0xAABBCCDD -> mem_wr=1 with 0xDD@0x200 and 0xCC@0x201; resp_valid_out[1] in G+3.
REQ-039 Both ports request continuously -> grants alternate 0,1,0,1.
REQ-040 flush_in pulsed in G+2 of a port-0 read -> no resp; IDLE next cycle; a pending port-1 request is granted afterwards.
REQ-041 MPMC_IO_STALL_EN defined; write len1 @0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for those 3 cycles, then byte written; resp 3 cycles late.
REQ-042 rdy_in low for 2 cycles mid-read -> mem_a is held and mem_wr=0; final rdata is unchanged versus the unpaused run.
